ex_muldiv_seq: RTL
==================

EX_MULDIV_SEQ -- requirements
Module: ex_muldiv_seq

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset: clk (rising edge), rst (active-low).
REQ-002 Ports: clk  in  1  clock; rst  in  1  async reset, active-low.
REQ-003 Ports: start  in  1  request, sampled only in IDLE; op  in  3  RV32M op (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-004 Ports: s1data  in  32  operand 1; s2data  in  32  operand 2; rd  in  5  destination register; regwe  in  1  write enable.
REQ-005 Ports: flush  in  1  abort current operation.
REQ-006 Ports: stall_req  out  1  hold the pipeline; busy  out  1  operation in progress; done  out  1  result valid, one-cycle pulse.
REQ-007 Ports: result  out  32; rd_o  out  5; regwe_o  out  1 (rd_o and regwe_o captured at start).

Function
REQ-008 FSM states: IDLE, CALC, FIX, DONE.
REQ-009 IDLE with start=1 at edge N: SHALL latch op, rd, regwe, operand magnitudes and result sign; next state CALC; iteration counter = 0.
REQ-010 CALC SHALL run exactly 32 cycles: shift-add multiply on the 64-bit accumulator, or restoring divide, one bit per cycle; counter 31 -> FIX.
REQ-011 FIX (1 cycle): apply two's-complement sign correction; select low word (MUL), high word (MULH*), quotient (DIV*), remainder (REM*) -> DONE.
REQ-012 DONE (1 cycle): done=1, result valid -> IDLE; total latency 34 cycles, i.e. done is high in cycle N+34.
REQ-013 Signedness: MULH signed x signed; MULHSU signed s1 x unsigned s2; MULHU, DIVU, REMU unsigned; remainder takes the dividend's sign.
REQ-014 Divide by zero: fast path, IDLE -> DONE; done in cycle N+1; quotient 0xFFFFFFFF; remainder = s1data.
REQ-015 Signed overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF): fast path, done at N+1; quotient 0x80000000; remainder 0.
REQ-016 busy=1 in CALC and FIX; busy=0 in IDLE and DONE.
REQ-017 stall_req = (IDLE and start) or CALC or FIX, combinational; stall_req=0 in DONE.
REQ-018 start while not in IDLE SHALL be ignored; no queueing.
REQ-019 flush=1 in any state: next state IDLE; done suppressed; result unchanged; flush wins over a simultaneous start.
REQ-020 result, rd_o and regwe_o SHALL hold their values after done until the next DONE.

Reset
REQ-021 rst=0: immediately state IDLE, counter 0, busy=0, done=0, result=0, rd_o=0, regwe_o=0, accumulators 0.
REQ-022 Reset mid-operation: the operation is discarded; no done after reset is released.
REQ-023 stall_req SHALL be 0 while rst=0.

Structure
REQ-024 Shared define header SHALL hold: op codes (MulDivOpBus, Mul..Remu), FSM state encodings, and the iteration count constant (32).
REQ-025 The block is a single module with no sub-module; the iteration datapath stays inline.

Verification
REQ-026 MUL 7 x 0xFFFFFFFD, start at N -> done at N+34, result 0xFFFFFFEB, rd_o = captured rd.
REQ-027 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> result 0xFFFFFFFF.
REQ-028 DIV 5/0 -> done at N+1, result 0xFFFFFFFF; REM 5/0 -> result 5; DIV 0x80000000/0xFFFFFFFF -> result 0x80000000.
REQ-029 REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF; DIVU 100/7 -> 14 at N+34; during the run busy=1 and stall_req=1, and a second start is ignored.
REQ-030 flush at N+10 -> IDLE at N+11, no done pulse; start at N+12 -> done at N+46.
REQ-031 rst low at N+5 -> all outputs 0 immediately; after release no done pulse and stall_req=0.

Source files
------------

// File: rtl/ex_muldiv_seq_pkg.sv
// Shared definitions for the sequential RV32M multiply/divide unit:
// op codes, FSM state encoding and iteration count.
package ex_muldiv_seq_pkg;

    typedef enum logic [2:0] {
        Mul    = 3'd0,
        Mulh   = 3'd1,
        Mulhsu = 3'd2,
        Mulhu  = 3'd3,
        Div    = 3'd4,
        Divu   = 3'd5,
        Rem    = 3'd6,
        Remu   = 3'd7
    } MulDivOpBus;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned ITER_COUNT = 32;

endpackage

// File: rtl/ex_muldiv_seq.sv
// Sequential RV32M multiply/divide: one bit per cycle over 32 cycles on
// operand magnitudes, then a single sign-fix cycle before the result pulse.
module ex_muldiv_seq
    import ex_muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] s1data,
    input  logic [31:0] s2data,
    input  logic [4:0]  rd,
    input  logic        regwe,
    input  logic        flush,
    output logic        stall_req,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_o,
    output logic        regwe_o
);

    state_t      r_state, w_next;
    MulDivOpBus  r_op, w_op;
    logic [4:0]  r_rd, r_cnt, r_rd_o;
    logic        r_regwe, r_neg, r_regwe_o;
    logic [31:0] r_opa, r_result;
    logic [63:0] r_acc;

    logic        w_accept, w_is_div, w_s1_neg, w_s2_neg, w_neg;
    logic        w_div_zero, w_div_ovf, w_fast;
    logic [31:0] w_s1_mag, w_s2_mag, w_fast_res, w_fix, w_quot, w_rem;
    logic [32:0] w_mul_sum, w_div_diff;
    logic [63:0] w_step, w_prod;

    // Operand decode at issue: magnitudes plus the sign the final result needs.
    always_comb begin
        w_op       = MulDivOpBus'(op);
        w_is_div   = op[2];
        w_accept   = (r_state == ST_IDLE) && start && !flush;
        w_s1_neg   = s1data[31] && (w_op inside {Mul, Mulh, Mulhsu, Div, Rem});
        w_s2_neg   = s2data[31] && (w_op inside {Mul, Mulh, Div, Rem});
        w_s1_mag   = w_s1_neg ? -s1data : s1data;
        w_s2_mag   = w_s2_neg ? -s2data : s2data;
        w_neg      = (w_op inside {Rem, Remu}) ? w_s1_neg : (w_s1_neg ^ w_s2_neg);
        w_div_zero = w_is_div && (s2data == '0);
        w_div_ovf  = (w_op inside {Div, Rem}) && (s1data == 32'h8000_0000) && (s2data == '1);
        w_fast     = w_div_zero || w_div_ovf;
        if (w_div_zero)
            w_fast_res = op[1] ? s1data : '1;
        else
            w_fast_res = op[1] ? '0 : 32'h8000_0000;
    end

    // Multiply: {hi,lo} with multiplier in lo, add-then-shift right.
    // Divide: {remainder,quotient} with dividend in lo, shift-left restoring.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opa : 32'd0)};
        w_div_diff = r_acc[63:31] - {1'b0, r_opa};
        if (r_op[2])
            w_step = w_div_diff[32] ? {r_acc[62:0], 1'b0}
                                    : {w_div_diff[31:0], r_acc[30:0], 1'b1};
        else
            w_step = {w_mul_sum, r_acc[31:1]};
    end

    always_comb begin
        w_prod = r_neg ? -r_acc : r_acc;
        w_quot = r_neg ? -r_acc[31:0] : r_acc[31:0];
        w_rem  = r_neg ? -r_acc[63:32] : r_acc[63:32];
        unique case (r_op)
            Mul:                  w_fix = w_prod[31:0];
            Mulh, Mulhsu, Mulhu:  w_fix = w_prod[63:32];
            Div, Divu:            w_fix = w_quot;
            default:              w_fix = w_rem;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (start) w_next = w_fast ? ST_DONE : ST_CALC;
            ST_CALC: if (r_cnt == 5'(ITER_COUNT - 1)) w_next = ST_FIX;
            ST_FIX:  w_next = ST_DONE;
            default: w_next = ST_IDLE;
        endcase
        if (flush) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op      <= Mul;
            r_rd      <= '0;
            r_regwe   <= 1'b0;
            r_neg     <= 1'b0;
            r_cnt     <= '0;
            r_opa     <= '0;
            r_acc     <= '0;
            r_result  <= '0;
            r_rd_o    <= '0;
            r_regwe_o <= 1'b0;
        end else if (w_accept) begin
            r_op    <= w_op;
            r_rd    <= rd;
            r_regwe <= regwe;
            r_neg   <= w_neg;
            r_cnt   <= '0;
            r_opa   <= w_is_div ? w_s2_mag : w_s1_mag;
            r_acc   <= {32'd0, (w_is_div ? w_s1_mag : w_s2_mag)};
            if (w_fast) begin
                r_result  <= w_fast_res;
                r_rd_o    <= rd;
                r_regwe_o <= regwe;
            end
        end else if (r_state == ST_CALC) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 5'd1;
        end else if (r_state == ST_FIX && !flush) begin
            r_result  <= w_fix;
            r_rd_o    <= r_rd;
            r_regwe_o <= r_regwe;
        end
    end

    assign busy      = (r_state == ST_CALC) || (r_state == ST_FIX);
    assign done      = (r_state == ST_DONE) && !flush;
    assign stall_req = rst && (((r_state == ST_IDLE) && start) || busy);
    assign result    = r_result;
    assign rd_o      = r_rd_o;
    assign regwe_o   = r_regwe_o;

endmodule
